// File: rtl/exp_pkg.sv
// exp_pkg: shared widths, saturation limits, FSM states and Horner coefficients for the exp scheduler.
package exp_pkg;
    localparam int X_W = 32;
    localparam int Y_W = 47;
    localparam logic [X_W-1:0] X_POS_MAX = 32'h0008_0000;
    localparam logic [X_W-1:0] X_NEG_MAX = 32'h0006_0000;
    // exp(x) ~ d + x*(c + x*(b + x*a)), coefficients in 22.25
    localparam logic [Y_W-1:0] COEF_A = 47'h0000_0055_5555;
    localparam logic [Y_W-1:0] COEF_B = 47'h0000_0100_0000;
    localparam logic [Y_W-1:0] COEF_C = 47'h0000_0200_0000;
    localparam logic [Y_W-1:0] COEF_D = 47'h0000_0200_0000;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/exp_rr_arbiter.sv
// exp_rr_arbiter: round-robin one-hot grant starting the search at ptr.
module exp_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);
    localparam int IW = $clog2(NUM_REQ);
    int k;
    // walking backwards lets the requester closest to ptr overwrite the others
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (en && req[k]) begin
                gnt = '0;
                gnt[k] = 1'b1;
                idx = IW'(k);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/exp_sched.sv
// exp_sched: shares one exp engine among NUM_REQ requesters; define EXP_SAT_EN to clamp out-of-range operands without the engine.
module exp_sched import exp_pkg::*; #(
    parameter int NUM_REQ       = 4,
    parameter int ENGINE_CYCLES = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*X_W-1:0]     req_x,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [X_W-1:0]             eng_x,
    output logic                       eng_clear,
    input  logic [Y_W-1:0]             eng_out,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [Y_W-1:0]             resp_data,
    output logic                       resp_sat
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ENGINE_CYCLES + 1);
    state_t state, state_nx;
    logic [IW-1:0] ptr, gnt_idx;
    logic [CW-1:0] cnt;
    logic [X_W-1:0] x_sel;
    logic gnt_any, sat_hi, sat_lo, last;

    exp_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .en(state == IDLE && !reset),
        .gnt(req_ready),
        .idx(gnt_idx),
        .any(gnt_any)
    );

    assign x_sel = req_x[int'(gnt_idx)*X_W +: X_W];
    assign last = cnt == CW'(ENGINE_CYCLES - 1);
    assign resp_valid = state == DONE;
`ifdef EXP_SAT_EN
    assign sat_hi = !x_sel[X_W-1] && x_sel[X_W-2:0] > X_POS_MAX[X_W-2:0];
    assign sat_lo = x_sel[X_W-1] && x_sel[X_W-2:0] > X_NEG_MAX[X_W-2:0];
`else
    assign sat_hi = 1'b0;
    assign sat_lo = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = gnt_any ? ((sat_hi || sat_lo) ? DONE : LOAD) : IDLE;
            LOAD: state_nx = RUN;
            RUN:  state_nx = last ? DONE : RUN;
            DONE: state_nx = resp_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            cnt <= '0;
            eng_x <= '0;
            eng_clear <= 1'b0;
            resp_id <= '0;
            resp_data <= '0;
            resp_sat <= 1'b0;
        end else begin
            eng_clear <= state == IDLE && gnt_any && !(sat_hi || sat_lo);
            cnt <= state == RUN ? cnt + 1'b1 : '0;
            if (state == IDLE && gnt_any) begin
                eng_x <= x_sel;
                resp_id <= gnt_idx;
                ptr <= gnt_idx == IW'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                resp_sat <= sat_hi || sat_lo;
                resp_data <= sat_hi ? '1 : '0;
            end
            if (state == RUN && last) resp_data <= eng_out;
        end
    end
endmodule

// File: doc/exp_sched.md
EXP_SCHED -- requirements
Module: exp_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one exp engine (2..8).
REQ-002 Parameter ENGINE_CYCLES, default 4, engine evaluation cycles after clear (Horner steps d,c,b,a).
REQ-003 clock  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester operand valid.
REQ-006 req_x  input  NUM_REQ*32  per-requester operand, sign-magnitude 1.15.16, requester k at bits [32k+31:32k].
REQ-007 req_ready  output  NUM_REQ  one-hot accept; at most one bit high per cycle.
REQ-008 eng_x  output  32  operand to exp engine, held stable from LOAD through end of RUN.
REQ-009 eng_clear  output  1  registered pulse restarting the engine step counter.
REQ-010 eng_out  input  47  engine result, 22.25 unsigned.
REQ-011 resp_valid  output  1  result valid.
REQ-012 resp_ready  input  1  consumer accepts result.
REQ-013 resp_id  output  clog2(NUM_REQ)  index of requester owning the result.
REQ-014 resp_data  output  47  result, 22.25.
REQ-015 resp_sat  output  1  result produced by range clamp, not by engine.

Function
REQ-016 FSM states IDLE, LOAD, RUN, DONE; one operation in flight at a time.
REQ-017 IDLE: req_ready combinationally asserts for the round-robin winner among req_valid; on that edge latch req_x into eng_x, winner into resp_id, go LOAD.
REQ-018 Round-robin: search starts at pointer; after a grant to g, pointer becomes (g+1) mod NUM_REQ.
REQ-019 LOAD: eng_clear high exactly this one cycle; go RUN with step counter 0.
REQ-020 RUN: counter increments each cycle; on counter = ENGINE_CYCLES-1 capture eng_out into resp_data, go DONE.
REQ-021 Latency: accept edge T -> resp_valid high from cycle T+2+ENGINE_CYCLES (T+6 at default).
REQ-022 DONE: resp_valid high, resp_data/resp_id/resp_sat stable until resp_ready sampled high; then IDLE, no grant in the DONE cycle.
REQ-023 req_ready is 0 in LOAD, RUN, DONE; requests may drop req_valid before grant without effect.
REQ-024 resp_ready while resp_valid low is ignored.
REQ-025 Default throughput at resp_ready=1: one result per 2+ENGINE_CYCLES+1 cycles.

Reset
REQ-026 Reset (any time, including mid-RUN or DONE) forces IDLE, pointer 0, counter 0, all outputs 0; in-flight operation discarded, no response.
REQ-027 First grant allowed on the first rising edge after reset deasserts.

Configuration
REQ-028 EXP_SAT_EN defined: in IDLE, accepted operand with sign 0 and magnitude > X_POS_MAX goes directly to DONE with resp_data all ones, resp_sat=1; sign 1 and magnitude > X_NEG_MAX goes to DONE with resp_data 0, resp_sat=1; latency T+1, no eng_clear.
REQ-029 EXP_SAT_EN undefined: all operands use the engine; resp_sat tied 0; no comparators synthesized.

Structure
REQ-030 Package exp_pkg: X_W=32, Y_W=47, X_POS_MAX=32'h0008_0000 (8.0), X_NEG_MAX=32'h0006_0000 (6.0), FSM state enum, Horner coefficients a,b,c,d.
REQ-031 Sub-module exp_rr_arbiter: NUM_REQ-wide round-robin arbiter (request vector, pointer, enable -> one-hot grant, index); FSM and datapath registers stay in exp_sched.

Verification
REQ-032 Requester 1 sends x=32'h0000_0000 -> req_ready[1] at T, eng_clear at T+1, resp_valid at T+6, resp_id=1, resp_data within 2^-14 relative of 47'h0000_0200_0000 (1.0).
REQ-033 All four req_valid held high -> grants in order 0,1,2,3,0 with every resp_id matching.
REQ-034 resp_ready low 10 cycles in DONE -> resp_valid, resp_data, resp_id constant; req_ready stays 0; release -> IDLE next cycle.
REQ-035 EXP_SAT_EN: x=32'h000A_0000 -> resp_valid at T+1, resp_data all ones, resp_sat=1; x=32'h8007_0000 -> resp_data 0, resp_sat=1; x=32'h0001_0000 -> engine path, T+6.
REQ-036 Reset pulsed mid-RUN -> all outputs 0 immediately, no response emitted, next request granted from requester 0 with normal latency.
